patram_arbiter: RTL and testbench

- Round-robin arbiter that shares the single Pattern-RAM read port between the PPU fetch engines: background, foreground and sprite engine.
- Each requester presents a 12-bit Pattern-RAM address with a req/gnt handshake.
- The arbiter drives the Pattern-RAM address and returns the 64-bit read data, tagged by a one-hot rvalid, a fixed latency after each grant.
- It sits between the engines and Pattern-RAM inside ppu_logic.

---
 rtl/patram_arbiter.sv | 104 ++++++++++
 tb/tb_patram_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/patram_arbiter.sv
// Round-robin arbiter sharing the single Pattern-RAM read port between the PPU
// fetch engines, with lock-driven bursts and a one-hot tagged read-return pipeline.
module patram_arbiter #(
  parameter int N_REQ     = 3,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ-1:0]      lock,
  input  logic [N_REQ*12-1:0]   addr,
  output logic [N_REQ-1:0]      gnt,
  output logic [N_REQ-1:0]      rvalid,
  output logic [63:0]           rddata,
  output logic [11:0]           patram_addr,
  input  logic [63:0]           patram_rddata,
  output logic                  busy
);
  localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int BCNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  logic [IDX_W-1:0]  r_last;
  logic [BCNT_W-1:0] r_bcnt;
  logic              r_pvld;
  logic [11:0]       r_haddr;
  logic [N_REQ-1:0]  r_tag_p [RD_LAT];
  logic [N_REQ-1:0]  r_rvalid;
  logic [63:0]       r_rddata;

  logic              w_lock_hit;
  logic              w_gvld;
  logic [IDX_W-1:0]  w_gidx;
  logic [N_REQ-1:0]  w_gnt;
  logic [11:0]       w_paddr;
  logic              w_busy;

  always_comb begin
    w_gvld     = 1'b0;
    w_gidx     = '0;
    w_gnt      = '0;
    w_lock_hit = r_pvld && req[r_last] && lock[r_last] &&
                 (r_bcnt < BCNT_W'(MAX_BURST - 1));
    if (w_lock_hit) begin
      w_gvld = 1'b1;
      w_gidx = r_last;
    end else begin
      // Search starts just past the last winner; the last winner itself is tried last.
      for (int s = 1; s <= N_REQ; s++) begin
        if (!w_gvld && req[(int'(r_last) + s) % N_REQ]) begin
          w_gvld = 1'b1;
          w_gidx = IDX_W'((int'(r_last) + s) % N_REQ);
        end
      end
    end
    if (!rst_n) w_gvld = 1'b0;
    if (w_gvld) w_gnt[w_gidx] = 1'b1;
    w_paddr = w_gvld ? addr[int'(w_gidx)*12 +: 12] : r_haddr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last  <= IDX_W'(N_REQ - 1);
      r_bcnt  <= '0;
      r_pvld  <= 1'b0;
      r_haddr <= '0;
    end else begin
      r_pvld <= w_gvld;
      if (w_gvld) begin
        r_last  <= w_gidx;
        r_haddr <= w_paddr;
        r_bcnt  <= w_lock_hit ? r_bcnt + 1'b1 : '0;
      end else begin
        r_bcnt <= '0;
      end
    end
  end

  // Read-return pipeline: tag stages track the RAM latency, then data and tag register together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) r_tag_p[i] <= '0;
      r_rvalid <= '0;
      r_rddata <= '0;
    end else begin
      r_tag_p[0] <= w_gnt;
      for (int i = 1; i < RD_LAT; i++) r_tag_p[i] <= r_tag_p[i-1];
      r_rvalid <= r_tag_p[RD_LAT-1];
      if (|r_tag_p[RD_LAT-1]) r_rddata <= patram_rddata;
    end
  end

  always_comb begin
    w_busy = |r_rvalid;
    for (int i = 0; i < RD_LAT; i++) w_busy = w_busy | (|r_tag_p[i]);
  end

  assign gnt         = w_gnt;
  assign patram_addr = w_paddr;
  assign rvalid      = r_rvalid;
  assign rddata      = r_rddata;
  assign busy        = w_busy;

endmodule

// File: tb/tb_patram_arbiter.sv
// Bench for patram_arbiter: directed scenarios plus a randomized run, with a
// grant model, a RAM model and a scoreboard of expected read returns.
module tb_patram_arbiter;
  localparam int N_REQ = 3, RD_LAT = 1, MAX_BURST = 4;
  localparam int WAIT_MAX = (N_REQ - 1) * MAX_BURST;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [N_REQ-1:0]    req = '0, lock = '0;
  logic [N_REQ*12-1:0] addr = '0;
  logic [N_REQ-1:0]    gnt, rvalid;
  logic [63:0]         rddata, patram_rddata;
  logic [11:0]         patram_addr;
  logic                busy;

  int n_tests = 0, n_fail = 0;

  patram_arbiter #(.N_REQ(N_REQ), .RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .lock(lock), .addr(addr),
    .gnt(gnt), .rvalid(rvalid), .rddata(rddata), .patram_addr(patram_addr),
    .patram_rddata(patram_rddata), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [63:0] ram_pipe [RD_LAT];
  always @(posedge clk) begin
    ram_pipe[0] <= {52'h0, patram_addr};
    for (int i = 1; i < RD_LAT; i++) ram_pipe[i] <= ram_pipe[i-1];
  end
  assign patram_rddata = ram_pipe[RD_LAT-1];

  typedef struct { logic [N_REQ-1:0] tag; logic [11:0] a; int due; } sb_t;
  sb_t sbq[$];

  int          m_last, m_bcnt, cyc;
  bit          m_pvld;
  logic [11:0] m_haddr;
  logic [63:0] m_rd;
  int          wait_c [N_REQ];

  logic [N_REQ-1:0] g_obs, r_obs;
  logic [11:0]      pa_obs;
  logic [63:0]      d_obs;
  logic             b_obs;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_gnt", gnt, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rddata", rddata, 0);
    check("rst_paddr", patram_addr, 0);
    check("rst_busy", busy, 0);
    sbq.delete();
    m_last = N_REQ - 1; m_bcnt = 0; m_pvld = 1'b0; m_haddr = '0; m_rd = '0;
    for (int i = 0; i < N_REQ; i++) wait_c[i] = 0;
    @(posedge clk); #1;
    cyc++;
    rst_n = 1'b1;
  endtask

  task automatic step();
    logic [N_REQ-1:0] eg, er;
    bit lk, found;
    int gi;
    @(negedge clk);
    g_obs = gnt; pa_obs = patram_addr; r_obs = rvalid; d_obs = rddata; b_obs = busy;
    check("busy", busy, sbq.size() != 0);
    er = '0;
    if (sbq.size() != 0 && sbq[0].due == cyc) er = sbq[0].tag;
    check("rvalid", rvalid, er);
    if (er != 0) begin
      m_rd = {52'h0, sbq[0].a};
      void'(sbq.pop_front());
    end
    check("rddata", rddata, m_rd);
    eg = '0; gi = 0; found = 1'b0;
    lk = m_pvld && req[m_last] && lock[m_last] && (m_bcnt < MAX_BURST - 1);
    if (lk) begin
      gi = m_last; found = 1'b1;
    end else begin
      for (int s = 1; s <= N_REQ; s++)
        if (!found && req[(m_last + s) % N_REQ]) begin
          gi = (m_last + s) % N_REQ; found = 1'b1;
        end
    end
    if (found) eg[gi] = 1'b1;
    check("gnt", gnt, eg);
    if (found) begin
      m_haddr = addr[gi*12 +: 12];
      sbq.push_back('{eg, m_haddr, cyc + RD_LAT + 1});
      m_bcnt = lk ? m_bcnt + 1 : 0;
      m_last = gi;
      m_pvld = 1'b1;
    end else begin
      m_bcnt = 0;
      m_pvld = 1'b0;
    end
    check("paddr", patram_addr, m_haddr);
    for (int i = 0; i < N_REQ; i++) begin
      if (req[i] && !gnt[i]) wait_c[i]++;
      else wait_c[i] = 0;
      if (req[i]) check("wait_bound", wait_c[i] > WAIT_MAX, 0);
    end
    cyc++;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [N_REQ-1:0] t1 [6];
    logic [N_REQ-1:0] t2 [6];
    logic [N_REQ-1:0] acc;
    t1 = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    t2 = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b100};
    cyc = 0;
    do_reset();

    // Plain rotation with all three requesting
    req = 3'b111; lock = 3'b000;
    addr = {12'h302, 12'h201, 12'h100};
    for (int k = 0; k < 6; k++) begin
      step();
      check("t1_gnt", g_obs, t1[k]);
      check("t1_paddr", pa_obs, 12'h100 + (k % 3) * 12'h101);
      if (k >= RD_LAT + 1) check("t1_rvalid", r_obs, t1[k-RD_LAT-1]);
    end
    req = '0;
    for (int k = 0; k < RD_LAT + 2; k++) step();

    // Locked burst with forced rotation
    do_reset();
    req = 3'b100; lock = 3'b100; addr = {12'h0A5, 12'h000, 12'h011};
    for (int k = 0; k < 6; k++) begin
      if (k == 2) req[0] = 1'b1;
      step();
      check("t2_gnt", g_obs, t2[k]);
      if (k == 4) req[0] = 1'b0;
    end
    req = '0; lock = '0;
    for (int k = 0; k < RD_LAT + 2; k++) step();

    // Single read, data return
    do_reset();
    req = 3'b010; addr = {12'h000, 12'h123, 12'h000};
    step();
    req = '0;
    step();
    check("t3_rvalid_early", r_obs, 0);
    step();
    check("t3_rvalid", r_obs, 3'b010);
    check("t3_rddata", d_obs, 64'h123);
    step();
    check("t3_rvalid_once", r_obs, 0);
    check("t3_rddata_hold", d_obs, 64'h123);

    // Idle after grant: address holds, busy drains
    req = 3'b001; addr = {12'h000, 12'h000, 12'h7FF};
    step();
    req = '0;
    step();
    check("t4_gnt", g_obs, 0);
    check("t4_paddr", pa_obs, 12'h7FF);
    check("t4_busy", b_obs, 1);
    step();
    check("t4_rvalid", r_obs, 3'b001);
    step();
    check("t4_busy_low", b_obs, 0);
    check("t4_paddr_hold", pa_obs, 12'h7FF);

    // Reset while a read is in flight
    req = 3'b001; addr = {12'h000, 12'h000, 12'h055};
    step();
    check("t5_busy_pre", busy, 1);
    do_reset();
    req = '0;
    acc = '0;
    for (int k = 0; k < RD_LAT + 3; k++) begin
      step();
      acc = acc | r_obs;
    end
    check("t5_no_rvalid", acc, 0);

    // Randomized traffic
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!(req[i] && !g_obs[i])) begin
          req[i] = ($urandom_range(0, 3) != 0);
          addr[i*12 +: 12] = 12'($urandom);
        end
        lock[i] = 1'($urandom_range(0, 1));
      end
      step();
    end
    req = '0; lock = '0;
    for (int k = 0; k < RD_LAT + 3; k++) step();
    check("sb_empty", sbq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
